// File: rtl/ps2_pkg.sv
// Scan codes, entry FSM encoding and scan-code-to-BCD helper for the PS/2 number-entry block.
// PS2_NUMPAD_EN adds the numeric keypad codes to the digit table.
package ps2_pkg;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

`ifdef PS2_NUMPAD_EN
    localparam logic [7:0] SC_KP0 = 8'h70;
    localparam logic [7:0] SC_KP1 = 8'h69;
    localparam logic [7:0] SC_KP2 = 8'h72;
    localparam logic [7:0] SC_KP3 = 8'h7A;
    localparam logic [7:0] SC_KP4 = 8'h6B;
    localparam logic [7:0] SC_KP5 = 8'h73;
    localparam logic [7:0] SC_KP6 = 8'h74;
    localparam logic [7:0] SC_KP7 = 8'h6C;
    localparam logic [7:0] SC_KP8 = 8'h75;
    localparam logic [7:0] SC_KP9 = 8'h7D;
`endif

    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } entry_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] bcd;
    } digit_t;

    function automatic digit_t scan_to_digit(input logic [7:0] code);
        digit_t r;
        r = '0;
        case (code)
            SC_D0:  r = '{1'b1, 4'd0};
            SC_D1:  r = '{1'b1, 4'd1};
            SC_D2:  r = '{1'b1, 4'd2};
            SC_D3:  r = '{1'b1, 4'd3};
            SC_D4:  r = '{1'b1, 4'd4};
            SC_D5:  r = '{1'b1, 4'd5};
            SC_D6:  r = '{1'b1, 4'd6};
            SC_D7:  r = '{1'b1, 4'd7};
            SC_D8:  r = '{1'b1, 4'd8};
            SC_D9:  r = '{1'b1, 4'd9};
`ifdef PS2_NUMPAD_EN
            SC_KP0: r = '{1'b1, 4'd0};
            SC_KP1: r = '{1'b1, 4'd1};
            SC_KP2: r = '{1'b1, 4'd2};
            SC_KP3: r = '{1'b1, 4'd3};
            SC_KP4: r = '{1'b1, 4'd4};
            SC_KP5: r = '{1'b1, 4'd5};
            SC_KP6: r = '{1'b1, 4'd6};
            SC_KP7: r = '{1'b1, 4'd7};
            SC_KP8: r = '{1'b1, 4'd8};
            SC_KP9: r = '{1'b1, 4'd9};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, falling-edge detect, 11-bit framing with
// odd-parity/start/stop checks and a watchdog that drops stalled partial frames.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frm_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic [1:0]      clk_sync;
    logic [1:0]      dat_sync;
    logic            clk_prev;
    logic            fall;
    logic [3:0]      bit_cnt;
    logic [9:0]      shift;     // {parity, D7..D0, start} once ten bits are in
    logic [WD_W-1:0] wd_cnt;

    assign fall = clk_prev & ~clk_sync[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would collapse the synchroniser.
    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
            bit_cnt  <= '0;
            shift    <= '0;
            wd_cnt   <= '0;
            rx_byte  <= '0;
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], PS2_CLK};
            dat_sync <= {dat_sync[0], PS2_DATA};
            clk_prev <= clk_sync[1];
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;

            if (fall) begin
                wd_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    // Stop bit is the live sample; odd parity over data plus parity bit.
                    if (!shift[0] && dat_sync[1] && (^shift[9:1])) begin
                        rx_byte  <= shift[8:1];
                        byte_vld <= 1'b1;
                    end else begin
                        frm_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift   <= {dat_sync[1], shift[9:1]};
                end
            end else if (bit_cnt != '0) begin
                if (wd_cnt == WD_LAST) begin
                    bit_cnt <= '0;
                    wd_cnt  <= '0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end else begin
                wd_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_keypad_entry.sv
// PS/2 number entry: decodes key releases into digits/edit commands and assembles an
// NDIG-digit BCD number offered with a valid/ack handshake. Option macro: PS2_NUMPAD_EN.
module ps2_keypad_entry
    import ps2_pkg::*;
#(
    parameter int NDIG        = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    input  logic              iNumAck,
    output logic [4*NDIG-1:0] oDigits,
    output logic [3:0]        oCount,
    output logic              oNumRdy,
    output logic              oErr,
    output logic [7:0]        oLED
);

    localparam logic [3:0] CNT_FULL = 4'(NDIG);

    logic [7:0]   rx_byte;
    logic         byte_vld;
    logic         frm_err;
    logic         brk;
    logic         ext;
    digit_t       dig;
    logic         act_digit;
    logic         act_bksp;
    logic         act_esc;
    logic         act_enter;
    entry_state_t state;
    entry_state_t state_nxt;

    ps2_frame_rx #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .CLK      (CLK),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .frm_err  (frm_err)
    );

    assign oErr = frm_err;

    // Prefix tracking; flags survive only until the next non-prefix byte.
    always_ff @(posedge CLK) begin
        if (reset) begin
            brk  <= 1'b0;
            ext  <= 1'b0;
            oLED <= '0;
        end else if (byte_vld) begin
            oLED <= rx_byte;
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                brk <= 1'b0;
                ext <= 1'b0;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        dig       = scan_to_digit(rx_byte);
        act_digit = 1'b0;
        act_bksp  = 1'b0;
        act_esc   = 1'b0;
        act_enter = 1'b0;
        if (byte_vld && brk && rx_byte != SC_EXT && rx_byte != SC_BRK) begin
            if (!ext) begin
                act_digit = dig.valid;
                act_bksp  = (rx_byte == SC_BKSP);
                act_esc   = (rx_byte == SC_ESC);
                act_enter = (rx_byte == SC_ENTER);
            end
`ifdef PS2_NUMPAD_EN
            else begin
                act_enter = (rx_byte == SC_ENTER);
            end
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= ENTRY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENTRY: if (act_enter && oCount == CNT_FULL) state_nxt = HOLD;
            HOLD:  if (iNumAck) state_nxt = ENTRY;
            default: state_nxt = ENTRY;
        endcase
    end

    always_comb begin
        oNumRdy = (state == HOLD);
    end

    // NOTE: the digit vector is ordinary flops feeding an output, so it is reset
    // with everything else rather than left undefined like a RAM would be.
    always_ff @(posedge CLK) begin
        if (reset) begin
            oCount  <= '0;
            oDigits <= '0;
        end else if (state == HOLD) begin
            if (iNumAck) begin
                oCount  <= '0;
                oDigits <= '0;
            end
        end else if (act_digit) begin
            if (oCount < CNT_FULL) begin
                oDigits[int'(oCount)*4 +: 4] <= dig.bcd;
                oCount                       <= oCount + 4'd1;
            end
        end else if (act_bksp) begin
            if (oCount != '0) begin
                oDigits[(int'(oCount)-1)*4 +: 4] <= 4'd0;
                oCount                           <= oCount - 4'd1;
            end
        end else if (act_esc) begin
            oCount  <= '0;
            oDigits <= '0;
        end
    end

endmodule
